// File: rtl/polyvec_eta_pack_pkg.sv
// Shared Dilithium parameters for the eta-packing slice: ring degree, coefficient
// width, byte width, FSM encodings and the ETA-to-symbol-width mapping.
package polyvec_eta_pack_pkg;

    localparam int N      = 256;
    localparam int COEF_W = 32;
    localparam int BYTE_W = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_EMIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // ETA=4 symbols span [0,8] and need 4 bits; ETA=2 symbols span [0,4] and need 3.
    function automatic int eta_sym_w(input int eta);
        return (eta == 4) ? 4 : 3;
    endfunction

endpackage

// File: rtl/polyvec_eta_pack_coef_map.sv
// Maps one signed coefficient c to its packed symbol ETA - c (truncated to W bits)
// and flags coefficients outside [-ETA, ETA].
module polyeta_coef_map
    import polyvec_eta_pack_pkg::*;
#(
    parameter int ETA = 4,
    parameter int W   = eta_sym_w(ETA)
) (
    input  logic signed [COEF_W-1:0] coef,
    output logic        [W-1:0]      sym,
    output logic                     out_of_range
);

    localparam logic signed [COEF_W-1:0] ETA_S = COEF_W'(ETA);

    // Out-of-range inputs still produce the wrapped low bits of ETA - c.
    function automatic logic [W-1:0] trunc_sym(input logic signed [COEF_W-1:0] c);
        return W'(ETA_S - c);
    endfunction

    always_comb begin
        sym          = trunc_sym(coef);
        out_of_range = (coef > ETA_S) || (coef < -ETA_S);
    end

endmodule

// File: rtl/polyvec_eta_pack.sv
// Streams a K-polynomial vector of small signed coefficients as eta-packed bytes
// over a valid/ready byte interface, one coefficient absorbed per FILL cycle.
module polyvec_eta_pack
    import polyvec_eta_pack_pkg::*;
#(
    parameter int K   = 6,
    parameter int ETA = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [K*N*COEF_W-1:0] v_in,
    output logic [BYTE_W-1:0]     out_byte,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  done,
    output logic                  range_err
);

    localparam int W     = eta_sym_w(ETA);
    localparam int TOTAL = K * N;
    localparam int IDX_W = $clog2(TOTAL + 1);
    localparam int CNT_W = 5;
    localparam int ACC_W = 16;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(TOTAL);
    localparam logic [CNT_W-1:0] SYM_BITS  = CNT_W'(W);
    localparam logic [CNT_W-1:0] BYTE_BITS = CNT_W'(BYTE_W);
    localparam logic [CNT_W-1:0] TWO_BYTES = CNT_W'(2 * BYTE_W);

    logic [1:0]               state;
    logic [ACC_W-1:0]         acc;
    logic [CNT_W-1:0]         cnt;
    logic [IDX_W-1:0]         idx;
    logic                     range_err_q;
    logic signed [COEF_W-1:0] coef_cur;
    logic [W-1:0]             sym;
    logic                     coef_oor;
    logic [CNT_W-1:0]         cnt_fill;

    always_comb coef_cur = v_in[idx*COEF_W +: COEF_W];

    polyeta_coef_map #(
        .ETA (ETA),
        .W   (W)
    ) u_coef_map (
        .coef         (coef_cur),
        .sym          (sym),
        .out_of_range (coef_oor)
    );

    assign cnt_fill = cnt + SYM_BITS;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            acc         <= '0;
            cnt         <= '0;
            idx         <= '0;
            range_err_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state       <= ST_FILL;
                        acc         <= '0;
                        cnt         <= '0;
                        idx         <= '0;
                        range_err_q <= 1'b0;
                    end
                end
                ST_FILL: begin
                    acc <= acc | (ACC_W'(sym) << cnt);
                    cnt <= cnt_fill;
                    idx <= idx + 1'b1;
                    if (coef_oor) begin
                        range_err_q <= 1'b1;
                    end
                    if (cnt_fill >= BYTE_BITS) begin
                        state <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        acc <= acc >> BYTE_W;
                        cnt <= cnt - BYTE_BITS;
                        // Symbol widths divide N*W into whole bytes, so the
                        // accumulator drains to empty at each polynomial boundary.
                        if (cnt >= TWO_BYTES) begin
                            state <= ST_EMIT;
                        end else if (idx != LAST_IDX) begin
                            state <= ST_FILL;
                        end else begin
                            state <= ST_DONE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_valid = (state == ST_EMIT);
    assign out_byte  = out_valid ? acc[BYTE_W-1:0] : '0;
    assign out_last  = out_valid && (idx == LAST_IDX) && (cnt < TWO_BYTES);
    assign done      = (state == ST_DONE);
    assign range_err = range_err_q;

endmodule
